// File: rtl/i2s_rx.sv
// I2S slave receiver.
// Brings SCK/LRCLK/SDATA into the system clock domain and collects one
// left/right sample pair per frame. A new pair is presented only after a
// complete, error-free left word and the right word that follows it.
module i2s_rx #(
    parameter int DATA_WIDTH  = 16,
    parameter int LEFT_LEVEL  = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sck,
    input  logic                  lrclk,
    input  logic                  sdata,
    output logic [DATA_WIDTH-1:0] left_chan,
    output logic [DATA_WIDTH-1:0] right_chan,
    output logic                  valid,
    output logic                  err
);

    localparam int            CW     = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] C_LAST = CW'(DATA_WIDTH - 1);
    localparam logic          C_LEFT = (LEFT_LEVEL != 0);

    // HUNT waits for the first left slot; SKIP is the slot-start rise (delay
    // bit, never shifted); SHIFT collects the word; WAIT ignores slot padding.
    typedef enum logic [1:0] {
        S_HUNT  = 2'd0,
        S_SKIP  = 2'd1,
        S_SHIFT = 2'd2,
        S_WAIT  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic [SYNC_STAGES-1:0] r_sck_sync;
    logic [SYNC_STAGES-1:0] r_lr_sync;
    logic [SYNC_STAGES-1:0] r_sd_sync;
    logic                   r_sck_last;
    logic                   r_lr_last;

    logic [DATA_WIDTH-2:0]  r_shreg;
    logic [CW-1:0]          r_bit_cnt;
    logic                   r_chan_left;
    logic                   r_left_good;
    logic [DATA_WIDTH-1:0]  r_left_hold;
    logic [DATA_WIDTH-1:0]  r_right_hold;
    logic                   r_load;
    logic                   r_err;
    logic                   r_valid;
    logic [DATA_WIDTH-1:0]  r_left_out;
    logic [DATA_WIDTH-1:0]  r_right_out;

    logic                   w_sck;
    logic                   w_lr;
    logic                   w_sd;
    logic                   w_sck_rise;
    logic                   w_slot_start;
    logic                   w_is_left;
    logic [DATA_WIDTH-1:0]  w_word;

    logic                   w_start_slot;
    logic                   w_do_shift;
    logic                   w_word_done;
    logic                   w_err;

    assign w_sck        = r_sck_sync[SYNC_STAGES-1];
    assign w_lr         = r_lr_sync[SYNC_STAGES-1];
    assign w_sd         = r_sd_sync[SYNC_STAGES-1];
    assign w_sck_rise   = w_sck & ~r_sck_last;
    assign w_slot_start = w_sck_rise & (w_lr != r_lr_last);
    assign w_is_left    = (w_lr == C_LEFT);
    assign w_word       = {r_shreg, w_sd};

    // Input synchronisers plus the extra SCK stage used for rising-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sck_sync <= '0;
            r_lr_sync  <= '0;
            r_sd_sync  <= '0;
            r_sck_last <= 1'b0;
        end else begin
            r_sck_sync <= {r_sck_sync[SYNC_STAGES-2:0], sck};
            r_lr_sync  <= {r_lr_sync[SYNC_STAGES-2:0], lrclk};
            r_sd_sync  <= {r_sd_sync[SYNC_STAGES-2:0], sdata};
            r_sck_last <= w_sck;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_HUNT;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and per-bit control; slot start is checked before any shift.
    always_comb begin
        w_next_state = r_state;
        w_start_slot = 1'b0;
        w_do_shift   = 1'b0;
        w_word_done  = 1'b0;
        w_err        = 1'b0;
        if (w_sck_rise) begin
            case (r_state)
                S_HUNT: begin
                    if (w_slot_start && w_is_left) begin
                        w_next_state = S_SKIP;
                        w_start_slot = 1'b1;
                    end
                end
                S_SKIP, S_SHIFT: begin
                    if (w_slot_start) begin
                        w_err        = 1'b1;
                        w_start_slot = 1'b1;
                        w_next_state = S_SKIP;
                    end else begin
                        w_do_shift   = 1'b1;
                        w_next_state = S_SHIFT;
                        if (r_bit_cnt == C_LAST) begin
                            w_word_done  = 1'b1;
                            w_next_state = S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (w_slot_start) begin
                        w_start_slot = 1'b1;
                        w_next_state = S_SKIP;
                    end
                end
                default: begin
                    w_next_state = S_HUNT;
                end
            endcase
        end
    end

    // Shift register, bit counter, channel hold registers and frame bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lr_last    <= ~C_LEFT;
            r_shreg      <= '0;
            r_bit_cnt    <= '0;
            r_chan_left  <= 1'b0;
            r_left_good  <= 1'b0;
            r_left_hold  <= '0;
            r_right_hold <= '0;
            r_load       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_load <= 1'b0;
            r_err  <= w_err;
            if (w_sck_rise) begin
                r_lr_last <= w_lr;
            end
            if (w_start_slot) begin
                r_chan_left <= w_is_left;
                r_bit_cnt   <= '0;
            end
            if (w_err || (w_start_slot && w_is_left)) begin
                r_left_good <= 1'b0;
            end
            if (w_do_shift) begin
                r_shreg   <= w_word[DATA_WIDTH-2:0];
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end
            if (w_word_done) begin
                if (r_chan_left) begin
                    r_left_hold <= w_word;
                    r_left_good <= 1'b1;
                end else begin
                    r_right_hold <= w_word;
                    r_load       <= r_left_good;
                    r_left_good  <= 1'b0;
                end
            end
        end
    end

    // Present a completed pair: both channels update together with a one-clk valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid     <= 1'b0;
            r_left_out  <= '0;
            r_right_out <= '0;
        end else begin
            r_valid <= r_load;
            if (r_load) begin
                r_left_out  <= r_left_hold;
                r_right_out <= r_right_hold;
            end
        end
    end

    assign left_chan  = r_left_out;
    assign right_chan = r_right_out;
    assign valid      = r_valid;
    assign err        = r_err;

endmodule

// File: tb/tb_i2s_rx.sv
// Testbench for i2s_rx: two instances (16-bit/left-high and 24-bit/left-low),
// slot-level reference model feeding a scoreboard, passive output monitors.
module tb_i2s_rx;

    typedef struct packed {
        logic [31:0] l;
        logic [31:0] r;
    } pair_t;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  sck   = 2'b00;
    logic [1:0]  lr    = 2'b10;
    logic [1:0]  sd    = 2'b00;

    logic [15:0] left0, right0;
    logic [23:0] left1, right1;
    logic        valid0, err0, valid1, err1;

    int    total = 0;
    int    bad   = 0;

    int    dwOf[2]      = '{16, 24};
    logic  leftLevel[2] = '{1'b1, 1'b0};
    bit    synced[2];
    bit    leftGood[2];
    logic [31:0] leftHold[2];
    pair_t lastPair[2];
    int    errExp[2];
    int    errSeen[2];
    logic [31:0] prevL[2];
    logic [31:0] prevR[2];
    pair_t q0[$];
    pair_t q1[$];

    always #10 clk = ~clk;

    i2s_rx #(.DATA_WIDTH(16), .LEFT_LEVEL(1), .SYNC_STAGES(2)) u0 (
        .clk(clk), .rst_n(rst_n), .sck(sck[0]), .lrclk(lr[0]), .sdata(sd[0]),
        .left_chan(left0), .right_chan(right0), .valid(valid0), .err(err0)
    );

    i2s_rx #(.DATA_WIDTH(24), .LEFT_LEVEL(0), .SYNC_STAGES(2)) u1 (
        .clk(clk), .rst_n(rst_n), .sck(sck[1]), .lrclk(lr[1]), .sdata(sd[1]),
        .left_chan(left1), .right_chan(right1), .valid(valid1), .err(err1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference model at slot granularity: a slot of len SCKs carries the
    // word only if len >= width+1 (delay bit plus the word); a short slot is
    // reported once the next slot begins and spoils the current frame.
    task automatic modelSlot(input int d, input bit isLeft, input logic [31:0] word, input int len);
        pair_t p;
        if (!synced[d] && !isLeft) return;
        synced[d] = 1'b1;
        if (len < dwOf[d] + 1) begin
            errExp[d]++;
            leftGood[d] = 1'b0;
            return;
        end
        if (isLeft) begin
            leftHold[d] = word;
            leftGood[d] = 1'b1;
        end else begin
            if (leftGood[d]) begin
                p.l = leftHold[d];
                p.r = word;
                if (d == 0) q0.push_back(p);
                else        q1.push_back(p);
                lastPair[d] = p;
            end
            leftGood[d] = 1'b0;
        end
    endtask

    task automatic resetModel();
        for (int d = 0; d < 2; d++) begin
            synced[d]   = 1'b0;
            leftGood[d] = 1'b0;
            lastPair[d] = '0;
        end
        q0.delete();
        q1.delete();
    endtask

    // One SCK period of 16 clk: data and word select change while SCK is low.
    task automatic sckBit(input int d, input logic lv, input logic b);
        @(negedge clk);
        sck[d] = 1'b0;
        lr[d]  = lv;
        sd[d]  = b;
        repeat (8) @(negedge clk);
        sck[d] = 1'b1;
        repeat (7) @(negedge clk);
    endtask

    // fill: 0/1 drive padding bits constant, 2 drives them randomly.
    task automatic sendSlot(input int d, input bit isLeft, input logic [31:0] word, input int len, input int fill);
        logic lv;
        logic b;
        int   dw;
        dw = dwOf[d];
        lv = isLeft ? leftLevel[d] : ~leftLevel[d];
        for (int i = 0; i < len; i++) begin
            if (i == 0)       b = 1'($urandom);
            else if (i <= dw) b = word[dw-i];
            else if (fill == 2) b = 1'($urandom);
            else              b = (fill == 1);
            sckBit(d, lv, b);
        end
    endtask

    task automatic slot(input int d, input bit isLeft, input logic [31:0] word, input int len, input int fill);
        modelSlot(d, isLeft, word, len);
        sendSlot(d, isLeft, word, len, fill);
    endtask

    task automatic applyStimulus(input int d, input logic [31:0] lw, input logic [31:0] rw, input int len, input int fill);
        slot(d, 1'b1, lw, len, fill);
        slot(d, 1'b0, rw, len, fill);
    endtask

    task automatic checkOutput(input int d, input string name);
        repeat (40) @(negedge clk);
        check({name, "_err_count"}, errSeen[d], errExp[d]);
        check({name, "_pending"}, (d == 0) ? q0.size() : q1.size(), 0);
        if (d == 0) begin
            check({name, "_left"},  {16'b0, left0},  lastPair[0].l);
            check({name, "_right"}, {16'b0, right0}, lastPair[0].r);
        end else begin
            check({name, "_left"},  {8'b0, left1},  lastPair[1].l);
            check({name, "_right"}, {8'b0, right1}, lastPair[1].r);
        end
    endtask

    task automatic monStep(input int d, input logic v, input logic e, input logic [31:0] l, input logic [31:0] r);
        pair_t p;
        if (rst_n) begin
            if (v) begin
                if (((d == 0) ? q0.size() : q1.size()) == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL dut%0d_unexpected_valid actual=%h/%h required=none", d, l, r);
                end else begin
                    p = (d == 0) ? q0.pop_front() : q1.pop_front();
                    check($sformatf("dut%0d_valid_left", d), l, p.l);
                    check($sformatf("dut%0d_valid_right", d), r, p.r);
                end
            end else if (l !== prevL[d] || r !== prevR[d]) begin
                total++;
                bad++;
                $display("[TB] FAIL dut%0d_output_changed_without_valid actual=%h/%h required=%h/%h",
                         d, l, r, prevL[d], prevR[d]);
            end
            if (e) errSeen[d]++;
        end
        prevL[d] = l;
        prevR[d] = r;
    endtask

    // Scoreboard monitors: sample outputs away from the active edge.
    always @(negedge clk) begin
        monStep(0, valid0, err0, {16'b0, left0}, {16'b0, right0});
        monStep(1, valid1, err1, {8'b0, left1}, {8'b0, right1});
    end

    initial begin
        logic quiet;
        logic [31:0] lw, rw;
        int   ll, rl;

        for (int d = 0; d < 2; d++) begin
            errExp[d]  = 0;
            errSeen[d] = 0;
            prevL[d]   = '0;
            prevR[d]   = '0;
        end
        resetModel();

        // Reset held while inputs toggle: everything stays quiet at zero.
        $display("[TB] reset with toggling inputs");
        rst_n = 1'b0;
        quiet = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            sck = 2'($urandom);
            lr  = 2'($urandom);
            sd  = 2'($urandom);
            if (valid0 || err0 || valid1 || err1 || (|left0) || (|right0) || (|left1) || (|right1))
                quiet = 1'b0;
        end
        check("reset_quiet", {31'b0, quiet}, 32'd1);
        sck = 2'b00;
        lr  = 2'b10;
        sd  = 2'b00;
        repeat (6) @(negedge clk);
        check("reset_left0", {16'b0, left0}, 32'h0);
        check("reset_right1", {8'b0, right1}, 32'h0);
        rst_n = 1'b1;

        // Single frame, padding bits driven high.
        $display("[TB] single frame");
        applyStimulus(0, 32'hA5C3, 32'h1234, 32, 1);
        checkOutput(0, "single");

        // Start mid-right-slot, then four back-to-back frames.
        $display("[TB] mid-slot start and back-to-back frames");
        @(negedge clk);
        rst_n = 1'b0;
        resetModel();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        slot(0, 1'b0, 32'hBEEF, 12, 2);
        applyStimulus(0, 32'h8000, 32'h7FFF, 32, 2);
        applyStimulus(0, 32'hFFFF, 32'h0001, 32, 2);
        applyStimulus(0, 32'h0000, 32'hFFFF, 32, 2);
        applyStimulus(0, {16'b0, 16'($urandom)}, {16'b0, 16'($urandom)}, 32, 2);
        checkOutput(0, "b2b");

        // Right slot cut to 10 SCKs, then a good frame.
        $display("[TB] short right slot");
        applyStimulus(0, 32'h1357, 32'h2468, 32, 2);
        slot(0, 1'b1, 32'hDEAD, 32, 2);
        slot(0, 1'b0, 32'hCAFE, 10, 2);
        check("short_hold_left", {16'b0, left0}, lastPair[0].l);
        check("short_hold_right", {16'b0, right0}, lastPair[0].r);
        applyStimulus(0, 32'h0F0F, 32'hF0F0, 32, 2);
        checkOutput(0, "short");

        // Reset in the middle of a left word; the slot remainder is too short.
        $display("[TB] reset mid-left-word");
        sendSlot(0, 1'b1, 32'h5A5A, 22, 2);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset_left", {16'b0, left0}, 32'h0);
        check("midreset_right", {16'b0, right0}, 32'h0);
        resetModel();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        slot(0, 1'b1, 32'h3C3C, 10, 2);
        slot(0, 1'b0, 32'h4242, 32, 2);
        applyStimulus(0, 32'h6789, 32'hABCD, 32, 2);
        checkOutput(0, "midreset");

        // Random words and slot lengths, some of them short.
        $display("[TB] randomized frames");
        for (int i = 0; i < 5; i++) begin
            lw = {16'b0, 16'($urandom)};
            rw = {16'b0, 16'($urandom)};
            ll = $urandom_range(32, 12);
            rl = $urandom_range(32, 12);
            slot(0, 1'b1, lw, ll, 2);
            slot(0, 1'b0, rw, rl, 2);
        end
        applyStimulus(0, {16'b0, 16'($urandom)}, {16'b0, 16'($urandom)}, 32, 2);
        checkOutput(0, "random");

        // 24-bit instance with left marked by LRCLK low.
        $display("[TB] 24-bit, left level low");
        applyStimulus(1, 32'h800001, 32'h7FFFFE, 32, 2);
        checkOutput(1, "w24_first");
        applyStimulus(1, {8'b0, 24'($urandom)}, {8'b0, 24'($urandom)}, 32, 2);
        checkOutput(1, "w24_random");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
